// File: rtl/fifo_rd_ptr_empty.sv
// rtl/fifo_rd_ptr_empty.sv - async FIFO read-domain pointer and empty flag; optional RD_UNDERFLOW_EN adds sticky underflow
module fifo_rd_ptr_empty #(
    parameter int ADDRBITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rd_en,
    input  logic [ADDRBITS:0]   wptr_gray,
    output logic [ADDRBITS-1:0] raddr,
    output logic [ADDRBITS:0]   readptr,
    output logic [ADDRBITS:0]   rptr_gray,
    output logic [ADDRBITS:0]   writeptrsynbinary,
    output logic                empty
`ifdef RD_UNDERFLOW_EN
    ,
    output logic                underflow
`endif
);

    logic [ADDRBITS:0] wptr_sync1;
    logic [ADDRBITS:0] wptr_sync2;
    logic [ADDRBITS:0] readptr_next;
    logic [ADDRBITS:0] rgray_next;
    logic              rd_ok;

    // Two-flop synchronizer for the Gray write pointer; nothing between the flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_sync1 <= '0;
            wptr_sync2 <= '0;
        end else begin
            wptr_sync1 <= wptr_gray;
            wptr_sync2 <= wptr_sync1;
        end
    end

    // Gray-to-binary of the synchronized write pointer: each bit is the XOR of all Gray bits at or above it.
    always_comb begin
        logic [ADDRBITS:0] shifted;
        shifted           = '0;
        writeptrsynbinary = '0;
        for (int i = 0; i <= ADDRBITS; i++) begin
            shifted              = wptr_sync2 >> i;
            writeptrsynbinary[i] = ^shifted;
        end
    end

    // Next read pointer and its Gray code; a read only advances when the FIFO is not empty.
    always_comb begin
        rd_ok        = rd_en & ~empty;
        readptr_next = readptr + {{ADDRBITS{1'b0}}, rd_ok};
        rgray_next   = readptr_next ^ (readptr_next >> 1);
    end

    // Pointer registers and empty flag; empty compares against the pre-edge synchronized pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            readptr   <= '0;
            rptr_gray <= '0;
            empty     <= 1'b1;
        end else begin
            readptr   <= readptr_next;
            rptr_gray <= rgray_next;
            empty     <= (rgray_next == wptr_sync2);
        end
    end

    assign raddr = readptr[ADDRBITS-1:0];

`ifdef RD_UNDERFLOW_EN
    // Sticky underflow: set by any read request while empty, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow <= 1'b0;
        end else if (rd_en && empty) begin
            underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_ptr_empty.sv
// tb/tb_fifo_rd_ptr_empty.sv - directed self-checking bench for fifo_rd_ptr_empty
module tb_fifo_rd_ptr_empty;

    logic       clk;
    logic       rst_n;
    logic       rd_en;
    logic [4:0] wptr_gray;
    logic [3:0] raddr;
    logic [4:0] readptr;
    logic [4:0] rptr_gray;
    logic [4:0] writeptrsynbinary;
    logic       empty;
`ifdef RD_UNDERFLOW_EN
    logic       underflow;
`endif

    int passed;
    int total;

    fifo_rd_ptr_empty #(.ADDRBITS(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rd_en             (rd_en),
        .wptr_gray         (wptr_gray),
        .raddr             (raddr),
        .readptr           (readptr),
        .rptr_gray         (rptr_gray),
        .writeptrsynbinary (writeptrsynbinary),
        .empty             (empty)
`ifdef RD_UNDERFLOW_EN
        ,
        .underflow         (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [4:0] exp_ptr  [5];
        logic [4:0] exp_gray [5];
        int k;
        passed = 0;
        total  = 0;

        // reset and idle
        rst_n     = 1'b0;
        rd_en     = 1'b0;
        wptr_gray = 5'b00000;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("rst_empty", empty, 1);
        check("rst_readptr", readptr, 0);
        check("rst_rgray", rptr_gray, 0);
        check("rst_wbin", writeptrsynbinary, 0);
        check("rst_raddr", raddr, 0);
`ifdef RD_UNDERFLOW_EN
        check("rst_underflow", underflow, 0);
`endif

        // single entry: sync latency then one read
        wptr_gray = 5'b00001;
        tick();
        check("t2_e1_wbin", writeptrsynbinary, 0);
        check("t2_e1_empty", empty, 1);
        tick();
        check("t2_e2_wbin", writeptrsynbinary, 1);
        check("t2_e2_empty", empty, 1);
        tick();
        check("t2_e3_empty", empty, 0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("t2_rd_readptr", readptr, 1);
        check("t2_rd_rgray", rptr_gray, 5'b00001);
        check("t2_rd_empty", empty, 1);

        // asynchronous reset mid-cycle, no clock edge
        #2;
        wptr_gray = 5'b00000;
        rst_n     = 1'b0;
        #1;
        check("arst_readptr", readptr, 0);
        check("arst_rgray", rptr_gray, 0);
        check("arst_empty", empty, 1);
        check("arst_wbin", writeptrsynbinary, 0);
        tick();

        // eight entries, rd_en held high
        rst_n     = 1'b1;
        wptr_gray = 5'b01100;
        rd_en     = 1'b1;
        tick();
        tick();
        check("t3_e2_wbin", writeptrsynbinary, 8);
        check("t3_e2_empty", empty, 1);
        tick();
        check("t3_e3_empty", empty, 0);
        check("t3_e3_readptr", readptr, 0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_raddr%0d", i), raddr, i);
            check($sformatf("t3_nempty%0d", i), empty, 0);
            tick();
        end
        check("t3_readptr8", readptr, 8);
        check("t3_empty8", empty, 1);
        tick();
        check("t3_ninth_readptr", readptr, 8);
        check("t3_ninth_empty", empty, 1);

        // preload to readptr=30 (Gray(30)=10001)
        wptr_gray = 5'b10001;
        k = 0;
        while (readptr != 5'd30 && k < 64) begin
            tick();
            k++;
        end
        check("t4_preload_readptr", readptr, 30);
        tick();
        check("t4_preload_empty", empty, 1);

        // wrap through 31 -> 0 -> 2
        wptr_gray = 5'b00011;
        tick();
        tick();
        check("t4_e2_empty", empty, 1);
        tick();
        check("t4_e3_empty", empty, 0);
        exp_ptr[0]  = 5'd30; exp_gray[0] = 5'b10001;
        exp_ptr[1]  = 5'd31; exp_gray[1] = 5'b10000;
        exp_ptr[2]  = 5'd0;  exp_gray[2] = 5'b00000;
        exp_ptr[3]  = 5'd1;  exp_gray[3] = 5'b00001;
        exp_ptr[4]  = 5'd2;  exp_gray[4] = 5'b00011;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4_readptr%0d", i), readptr, exp_ptr[i]);
            check($sformatf("t4_rgray%0d", i), rptr_gray, exp_gray[i]);
            if (i < 4) tick();
        end
        check("t4_empty_at2", empty, 1);
        rd_en = 1'b0;

        // one more entry (Gray(3)=00010), settle
        wptr_gray = 5'b00010;
        tick();
        tick();
        tick();
        check("t5_settle_empty", empty, 0);
        check("t5_settle_wbin", writeptrsynbinary, 3);

        // last read coincides with sync2 advancing to Gray(5)=00111
        wptr_gray = 5'b00111;
        tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("t5_co_readptr", readptr, 3);
        check("t5_co_wbin", writeptrsynbinary, 5);
        check("t5_co_false_empty", empty, 1);
        tick();
        check("t5_after_empty", empty, 0);
        check("t5_after_readptr", readptr, 3);

`ifdef RD_UNDERFLOW_EN
        // underflow: read while empty, sticky until reset
        rst_n     = 1'b0;
        wptr_gray = 5'b00000;
        tick();
        rst_n = 1'b1;
        tick();
        check("uf_clear", underflow, 0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("uf_set", underflow, 1);
        check("uf_readptr", readptr, 0);
        tick();
        tick();
        check("uf_sticky", underflow, 1);
        rst_n = 1'b0;
        #1;
        check("uf_rst", underflow, 0);
        rst_n = 1'b1;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
